// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder_if
// Brief    : Key-event valid/ready channel from the scancode decoder.
// Revision : 1.0
// ============================================================================
interface ps2_scancode_decoder_if;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       ev_valid;
    logic       ev_ready;

    modport master (
        output ev_code,
        output ev_break,
        output ev_ext,
        output ev_valid,
        input  ev_ready
    );

    modport slave (
        input  ev_code,
        input  ev_break,
        input  ev_ext,
        input  ev_valid,
        output ev_ready
    );
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder
// Brief    : PS/2 Set-2 prefix stripper with CDC strobe and key-event FIFO.
// Revision : 1.0
// ============================================================================
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [7:0]        byte_in,
    input  wire logic              byte_valid,
    output logic                   overflow,
    ps2_scancode_decoder_if.master ev
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_PW = c_AW + 1;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_EXT     = 3'd1;
    localparam logic [2:0] c_BRK     = 3'd2;
    localparam logic [2:0] c_EXT_BRK = 3'd3;
    localparam logic [2:0] c_PAUSE   = 3'd4;

    function automatic logic f_is_ctrl(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_strobe;
    logic [7:0]             r_hold;
    logic                   r_hold_vld;

    // byte_in is already stable when the strobe fires, so only the valid is synchronised.
    assign w_strobe = r_sync[SYNC_STAGES-1] & ~r_hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync     <= '0;
            r_hist     <= 1'b0;
            r_hold     <= 8'h00;
            r_hold_vld <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], byte_valid};
            r_hist     <= r_sync[SYNC_STAGES-1];
            r_hold_vld <= w_strobe;
            if (w_strobe) begin
                r_hold <= byte_in;
            end
        end
    end

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [2:0] r_skip;
    logic [2:0] w_skip_nxt;
    logic       w_emit;
    logic [9:0] w_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        if (r_hold_vld) begin
            case (r_state)
                c_IDLE: begin
                    if (r_hold == 8'hE0) begin
                        w_state_nxt = c_EXT;
                    end else if (r_hold == 8'hF0) begin
                        w_state_nxt = c_BRK;
                    end else if (r_hold == 8'hE1) begin
                        w_state_nxt = c_PAUSE;
                        w_skip_nxt  = 3'd7;
                    end
                end
                c_EXT: begin
                    if (r_hold == 8'hF0) begin
                        w_state_nxt = c_EXT_BRK;
                    end else if (r_hold != 8'hE0) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                c_PAUSE: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Event word layout is {ext, break, code}.
    always_comb begin
        w_emit  = 1'b0;
        w_wdata = {2'b00, r_hold};
        if (r_hold_vld) begin
            case (r_state)
                c_IDLE: begin
                    w_emit = !(r_hold inside {8'hE0, 8'hF0, 8'hE1}) && !f_is_ctrl(r_hold);
                end
                c_EXT: begin
                    w_emit  = !(r_hold inside {8'hE0, 8'hF0}) && !f_is_ctrl(r_hold);
                    w_wdata = {2'b10, r_hold};
                end
                c_BRK: begin
                    w_emit  = !f_is_ctrl(r_hold);
                    w_wdata = {2'b01, r_hold};
                end
                c_EXT_BRK: begin
                    w_emit  = !f_is_ctrl(r_hold);
                    w_wdata = {2'b11, r_hold};
                end
                c_PAUSE: begin
                    w_emit  = (r_skip == 3'd1);
                    w_wdata = {2'b10, 8'hE1};
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr;
    logic [c_PW-1:0] r_rd;
    logic [c_PW-1:0] w_wr_nxt;
    logic [c_PW-1:0] w_rd_nxt;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic [9:0]      w_head_nxt;
    logic [9:0]      r_head;
    logic            r_valid;
    logic            r_overflow;

    assign w_full   = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_pop    = r_valid & ev.ev_ready;
    assign w_wr     = w_emit & (~w_full | w_pop);
    assign w_wr_nxt = r_wr + c_PW'(w_wr);
    assign w_rd_nxt = r_rd + c_PW'(w_pop);

    // The head register looks ahead one entry so the outputs can be flops with no fall-through.
    assign w_head_nxt = (w_wr && (w_rd_nxt[c_AW-1:0] == r_wr[c_AW-1:0])) ?
                        w_wdata : r_mem[w_rd_nxt[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr[c_AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_head     <= 10'h000;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_rd_nxt != w_wr_nxt);
            if (w_emit && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ev.ev_code  = r_head[7:0];
    assign ev.ev_break = r_head[8];
    assign ev.ev_ext   = r_head[9];
    assign ev.ev_valid = r_valid;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_scancode_decoder
// Brief    : Vector table, corner sequences and random stream vs. prefix model.
// Revision : 1.0
// ============================================================================
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       overflow;
    logic       ready_cmd;
    logic       rand_rdy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] pops [$];
    logic [9:0] exp_q [$];

    ps2_scancode_decoder_if ev_if ();

    ps2_scancode_decoder #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .overflow   (overflow),
        .ev         (ev_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ev_if.ev_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    // An accepted event is recorded one half-cycle before the edge that pops it.
    always @(negedge clk) begin
        if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1)
            pops.push_back({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pops(input string name, input int start);
        chk({name, " count"}, pops.size() - start, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i < pops.size())
                chk($sformatf("%s ev%0d", name, i), {22'd0, pops[start + i]}, {22'd0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        @(posedge clk);
        #1;
        byte_in    = b;
        byte_valid = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    // Reference: pending prefixes as flags, pause as a remaining-bytes count.
    bit m_ext;
    bit m_brk;
    int m_pause;

    function automatic bit is_ctrl(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) exp_q.push_back({2'b10, 8'hE1});
        end else if (!m_ext && !m_brk) begin
            if (b == 8'hE0)      m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE1) m_pause = 7;
            else if (!is_ctrl(b)) exp_q.push_back({2'b00, b});
        end else if (m_ext && !m_brk) begin
            if (b == 8'hF0)      m_brk = 1'b1;
            else if (b == 8'hE0) m_ext = 1'b1;
            else begin
                if (!is_ctrl(b)) exp_q.push_back({2'b10, b});
                m_ext = 1'b0;
            end
        end else begin
            if (!is_ctrl(b)) exp_q.push_back({m_ext, 1'b1, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    typedef struct {
        int          n;
        logic [63:0] bytes;
        int          ne;
        logic [19:0] evs;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int start;
        logic [7:0] b;

        vecs[0]  = '{1, 64'h1C00_0000_0000_0000, 1, {10'h01C, 10'h000}};
        vecs[1]  = '{2, 64'hF01C_0000_0000_0000, 1, {10'h11C, 10'h000}};
        vecs[2]  = '{2, 64'hE075_0000_0000_0000, 1, {10'h275, 10'h000}};
        vecs[3]  = '{3, 64'hE0F0_7500_0000_0000, 1, {10'h375, 10'h000}};
        vecs[4]  = '{8, 64'hE114_77E1_F014_F077, 1, {10'h2E1, 10'h000}};
        vecs[5]  = '{5, 64'hAAFA_E0FE_1C00_0000, 1, {10'h01C, 10'h000}};
        vecs[6]  = '{2, 64'hF0F0_0000_0000_0000, 1, {10'h1F0, 10'h000}};
        vecs[7]  = '{3, 64'hE0E0_6B00_0000_0000, 1, {10'h26B, 10'h000}};
        vecs[8]  = '{3, 64'hF0AA_1C00_0000_0000, 1, {10'h01C, 10'h000}};
        vecs[9]  = '{4, 64'hE0F0_E01C_0000_0000, 2, {10'h3E0, 10'h01C}};
        vecs[10] = '{4, 64'h00FF_EE5A_0000_0000, 1, {10'h05A, 10'h000}};

        reset = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        ready_cmd = 1'b0; rand_rdy = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst ev_valid", ev_if.ev_valid, 0);
        chk("rst ev_code",  ev_if.ev_code,  0);
        chk("rst ev_break", ev_if.ev_break, 0);
        chk("rst ev_ext",   ev_if.ev_ext,   0);
        chk("rst overflow", overflow,       0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Latency: first edge seeing byte_valid high is N; ev_valid appears after N+3.
        @(posedge clk); #1;
        byte_in = 8'h1C; byte_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("latency edge N+%0d valid", k - 1), ev_if.ev_valid, 0);
        end
        @(posedge clk); #1;
        chk("latency edge N+3 valid", ev_if.ev_valid, 1);
        chk("latency head", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, 10'h01C);
        repeat (8) @(posedge clk);
        #1; byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        send_byte(8'hF0, 3, 3);
        send_byte(8'h1C, 3, 3);
        repeat (4) @(posedge clk); #1;
        chk("hold head", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, 10'h01C);
        start = pops.size();
        ready_cmd = 1'b1;
        repeat (8) @(posedge clk);
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h11C);
        check_pops("long valid + break", start);

        for (int v = 0; v < 11; v++) begin
            start = pops.size();
            for (int j = 0; j < vecs[v].n; j++)
                send_byte(vecs[v].bytes[63 - 8 * j -: 8], 3, 3);
            repeat (12) @(posedge clk);
            for (int j = 0; j < vecs[v].ne; j++)
                exp_q.push_back(vecs[v].evs[19 - 10 * j -: 10]);
            check_pops($sformatf("vec%0d", v), start);
        end

        // Overflow: fifth event is dropped while the consumer stalls.
        ready_cmd = 1'b0;
        repeat (2) @(posedge clk);
        send_byte(8'h15, 3, 3);
        send_byte(8'h1D, 3, 3);
        send_byte(8'h24, 3, 3);
        send_byte(8'h2D, 3, 3);
        send_byte(8'h2C, 3, 3);
        repeat (6) @(posedge clk); #1;
        chk("ovf flag", overflow, 1);
        chk("ovf valid", ev_if.ev_valid, 1);
        chk("ovf head", ev_if.ev_code, 8'h15);
        start = pops.size();
        ready_cmd = 1'b1;
        repeat (10) @(posedge clk); #1;
        exp_q.push_back(10'h015);
        exp_q.push_back(10'h01D);
        exp_q.push_back(10'h024);
        exp_q.push_back(10'h02D);
        check_pops("ovf drain", start);
        chk("ovf sticky", overflow, 1);
        chk("ovf empty", ev_if.ev_valid, 0);

        // Reset after a lone E0 must discard the prefix.
        send_byte(8'hE0, 3, 3);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst ev_valid", ev_if.ev_valid, 0);
        chk("midrst ev_code",  ev_if.ev_code,  0);
        chk("midrst overflow", overflow,       0);
        @(posedge clk); #1;
        reset = 1'b1;
        start = pops.size();
        send_byte(8'h75, 3, 3);
        repeat (10) @(posedge clk);
        exp_q.push_back(10'h075);
        check_pops("midrst 75", start);

        // Random byte stream with random consumer stalls.
        m_ext = 1'b0; m_brk = 1'b0; m_pause = 0;
        start = pops.size();
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'hE1;
                3: b = 8'hAA;
                4: b = 8'hFA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_byte(b, $urandom_range(2, 6), $urandom_range(2, 5));
            model_byte(b);
        end
        repeat (20) @(posedge clk);
        rand_rdy = 1'b0;
        ready_cmd = 1'b1;
        repeat (4) @(posedge clk);
        check_pops("random", start);
        chk("random overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
